aes_round_ctrl: RTL and testbench

Iterative AES encryption round sequencer. Accepts one 128-bit plaintext block per valid/ready handshake, applies the initial round-key XOR, then iterates NR rounds through an external combinational round-function block. Each round's output is XORed with the matching round key read from an external key store. The block owns the state register, round counter and output handshake, and sits between the cipher's stream interface and the round datapath/key storage.

---
 rtl/aes_round_ctrl.sv | 109 ++++++++++
 tb/tb_aes_round_ctrl.sv | 307 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/aes_round_ctrl.sv
// aes_round_ctrl: iterative AES encryption sequencer owning the state register, round counter and handshakes.
// Define AES_ROUND_CTRL_ABORT_EN to add an abort input that cancels the block in flight.
module aes_round_ctrl #(
  parameter int unsigned NR = 10
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] in_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] out_data,
  output logic [3:0]   rk_addr,
  input  logic [127:0] rk_data,
  output logic [127:0] rf_in,
  output logic         rf_final,
  input  logic [127:0] rf_out,
`ifdef AES_ROUND_CTRL_ABORT_EN
  input  logic         abort,
`endif
  output logic         busy
);

  localparam int unsigned BlkW = 128;
  localparam int unsigned RndW = 4;
  localparam logic [RndW-1:0] LastRnd = RndW'(NR);

  typedef enum logic [1:0] {IDLE, ROUND, DONE} state_e;

  state_e            state_q, state_d;
  logic [RndW-1:0]   rnd_q, rnd_d;
  logic [BlkW-1:0]   data_q, data_d;
  logic              abort_c;

`ifdef AES_ROUND_CTRL_ABORT_EN
  assign abort_c = abort && (state_q != IDLE);
`else
  assign abort_c = 1'b0;
`endif

  // Next state, key-store address and input handshake.
  always_comb begin
    state_d  = state_q;
    rnd_d    = rnd_q;
    data_d   = data_q;
    in_ready = 1'b0;
    rk_addr  = '0;
    case (state_q)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          data_d  = in_data ^ rk_data;
          rnd_d   = RndW'(1);
          state_d = ROUND;
        end
      end
      ROUND: begin
        rk_addr = rnd_q;
        data_d  = rf_out ^ rk_data;
        if (rnd_q == LastRnd) begin
          state_d = DONE;
        end else begin
          rnd_d = rnd_q + RndW'(1);
        end
      end
      DONE: begin
        in_ready = out_ready && !abort_c;
        rk_addr  = LastRnd;
        if (out_ready && !abort_c) begin
          if (in_valid) begin
            // Bypass: hand off the result and load the next block in one cycle.
            rk_addr = '0;
            data_d  = in_data ^ rk_data;
            rnd_d   = RndW'(1);
            state_d = ROUND;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
    if (abort_c) begin
      state_d = IDLE;
      rnd_d   = '0;
      data_d  = data_q;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      rnd_q   <= '0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      rnd_q   <= rnd_d;
      data_q  <= data_d;
    end
  end

  assign out_valid = (state_q == DONE);
  assign out_data  = data_q;
  assign rf_in     = data_q;
  assign rf_final  = (state_q == ROUND) && (rnd_q == LastRnd);
  assign busy      = (state_q != IDLE);

endmodule

// File: tb/tb_aes_round_ctrl.sv
// tb_aes_round_ctrl: drives aes_round_ctrl (NR=10 and NR=14) against a software AES model
// providing the round function, key expansion and expected ciphertexts.
module tb_aes_round_ctrl;

  logic         clk;
  logic         rst;
  logic         in_valid, in_ready, out_valid, out_ready, rf_final, busy;
  logic [127:0] in_data, out_data, rk_data, rf_in, rf_out;
  logic [3:0]   rk_addr;

  logic         iv14, ir14, ov14, or14, rff14, bsy14;
  logic [127:0] id14, od14, rkd14, rfi14, rfo14;
  logic [3:0]   rka14;

`ifdef AES_ROUND_CTRL_ABORT_EN
  logic abort, abort14;
`endif

  logic [127:0] rk10 [16];
  logic [127:0] rk14 [16];
  logic [31:0]  w [60];

  int checks = 0;
  int errors = 0;

  aes_round_ctrl #(.NR(10)) u_dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .rk_addr(rk_addr), .rk_data(rk_data),
    .rf_in(rf_in), .rf_final(rf_final), .rf_out(rf_out),
`ifdef AES_ROUND_CTRL_ABORT_EN
    .abort(abort),
`endif
    .busy(busy)
  );

  aes_round_ctrl #(.NR(14)) u_dut14 (
    .clk(clk), .rst(rst),
    .in_valid(iv14), .in_ready(ir14), .in_data(id14),
    .out_valid(ov14), .out_ready(or14), .out_data(od14),
    .rk_addr(rka14), .rk_data(rkd14),
    .rf_in(rfi14), .rf_final(rff14), .rf_out(rfo14),
`ifdef AES_ROUND_CTRL_ABORT_EN
    .abort(abort14),
`endif
    .busy(bsy14)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, aa, bb;
    p = '0; aa = a; bb = b;
    for (int i = 0; i < 8; i++) begin
      if (bb[0]) p = p ^ aa;
      aa = {aa[6:0], 1'b0} ^ (aa[7] ? 8'h1b : 8'h00);
      bb = bb >> 1;
    end
    return p;
  endfunction

  // S-box from its definition: GF(2^8) inverse (x^254) followed by the affine map.
  function automatic logic [7:0] sbox(input logic [7:0] x);
    logic [7:0]  r, inv;
    logic [15:0] d;
    r = x;
    for (int i = 0; i < 6; i++) r = gmul(gmul(r, r), x);
    inv = gmul(r, r);
    d = {inv, inv};
    return inv ^ d[14:7] ^ d[13:6] ^ d[12:5] ^ d[11:4] ^ 8'h63;
  endfunction

  function automatic logic [31:0] subword(input logic [31:0] v);
    return {sbox(v[31:24]), sbox(v[23:16]), sbox(v[15:8]), sbox(v[7:0])};
  endfunction

  function automatic logic [127:0] aes_round(input logic [127:0] s, input logic fin);
    logic [7:0]   b [16];
    logic [7:0]   t [16];
    logic [7:0]   a0, a1, a2, a3;
    logic [127:0] o;
    for (int i = 0; i < 16; i++) b[i] = sbox(s[127-8*i -: 8]);
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++) t[r+4*c] = b[r+4*((c+r)%4)];
    if (!fin) begin
      for (int c = 0; c < 4; c++) begin
        a0 = t[4*c]; a1 = t[4*c+1]; a2 = t[4*c+2]; a3 = t[4*c+3];
        t[4*c]   = gmul(a0, 8'h02) ^ gmul(a1, 8'h03) ^ a2 ^ a3;
        t[4*c+1] = a0 ^ gmul(a1, 8'h02) ^ gmul(a2, 8'h03) ^ a3;
        t[4*c+2] = a0 ^ a1 ^ gmul(a2, 8'h02) ^ gmul(a3, 8'h03);
        t[4*c+3] = gmul(a0, 8'h03) ^ a1 ^ a2 ^ gmul(a3, 8'h02);
      end
    end
    for (int i = 0; i < 16; i++) o[127-8*i -: 8] = t[i];
    return o;
  endfunction

  function automatic logic [127:0] ref10(input logic [127:0] pt);
    logic [127:0] s;
    s = pt ^ rk10[0];
    for (int r = 1; r <= 10; r++) s = aes_round(s, r == 10) ^ rk10[r];
    return s;
  endfunction

  task automatic expand(input logic [255:0] key, input int nk, input int nr);
    logic [31:0] t;
    logic [7:0]  rc;
    rc = 8'h01;
    for (int i = 0; i < nk; i++) w[i] = key[255-32*i -: 32];
    for (int i = nk; i < 4*(nr+1); i++) begin
      t = w[i-1];
      if (i % nk == 0) begin
        t  = subword({t[23:0], t[31:24]}) ^ {rc, 24'h0};
        rc = gmul(rc, 8'h02);
      end else if (nk > 6 && i % nk == 4) begin
        t = subword(t);
      end
      w[i] = w[i-nk] ^ t;
    end
  endtask

  assign rk_data = rk10[rk_addr];
  assign rf_out  = aes_round(rf_in, rf_final);
  assign rkd14   = rk14[rka14];
  assign rfo14   = aes_round(rfi14, rff14);

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h expected=%h", tag, got, exp);
    end
  endtask

  function automatic logic [127:0] rand128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  task automatic check_reset_outputs(input string tag);
    check({tag, "_ctl"}, 128'({out_valid, busy, in_ready, rk_addr, rf_final}),
          128'({1'b0, 1'b0, 1'b1, 4'd0, 1'b0}));
    check({tag, "_out_data"}, out_data, 128'(0));
    check({tag, "_rf_in"}, rf_in, 128'(0));
  endtask

  // One block from IDLE: latency, key-index sequence, ciphertext, optional backpressure hold.
  task automatic run_one(input string tag, input logic [127:0] pt, input logic [127:0] exp,
                         input int hold);
    int   cnt;
    logic seq_ok, stab_ok;
    in_data = pt; in_valid = 1'b1; out_ready = 1'b0;
    #1;
    check({tag, "_accept"}, 128'({in_ready, rk_addr}), 128'({1'b1, 4'd0}));
    @(posedge clk); #1;
    in_valid = 1'b0;
    cnt = 1; seq_ok = 1'b1;
    while (!out_valid && cnt < 40) begin
      if (rk_addr != 4'(cnt)) seq_ok = 1'b0;
      @(posedge clk); #1;
      cnt++;
    end
    check({tag, "_latency"}, 128'(cnt), 128'(11));
    check({tag, "_rk_seq"}, 128'(seq_ok), 128'(1));
    check({tag, "_data"}, out_data, exp);
    stab_ok = 1'b1;
    for (int i = 0; i < hold; i++) begin
      @(posedge clk); #1;
      if (out_data !== exp || !out_valid || !busy || in_ready || rk_addr != 4'd10) stab_ok = 1'b0;
    end
    if (hold > 0) check({tag, "_hold"}, 128'(stab_ok), 128'(1));
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check({tag, "_released"}, 128'({out_valid, busy}), 128'(0));
  endtask

  initial begin
    logic [127:0] pt, exp;
    int cnt;

    rst = 1'b1; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
    iv14 = 1'b0; id14 = '0; or14 = 1'b0;
`ifdef AES_ROUND_CTRL_ABORT_EN
    abort = 1'b0; abort14 = 1'b0;
`endif
    for (int i = 0; i < 16; i++) begin rk10[i] = '0; rk14[i] = '0; end
    expand({128'h000102030405060708090a0b0c0d0e0f, 128'h0}, 4, 10);
    for (int r = 0; r <= 10; r++) rk10[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
    expand(256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f, 8, 14);
    for (int r = 0; r <= 14; r++) rk14[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};

    repeat (2) @(posedge clk);
    #1;
    check_reset_outputs("reset");
    rst = 1'b0;
    @(posedge clk); #1;

    // FIPS-197 C.1 with 5 cycles of backpressure
    run_one("c1", 128'h00112233445566778899aabbccddeeff, 128'h69c4e0d86a7b0430d8cdb78070b4c55a, 5);

    // Random blocks against the software model, DONE->IDLE each time
    for (int k = 0; k < 3; k++) begin
      pt = rand128();
      run_one("rand", pt, ref10(pt), int'($urandom_range(0, 3)));
    end

    // Back-to-back through the DONE->ROUND bypass
    pt = rand128();
    in_data = pt; in_valid = 1'b1; out_ready = 1'b1;
    #1;
    check("b2b_first_ready", 128'(in_ready), 128'(1));
    for (int b = 0; b < 4; b++) begin
      exp = ref10(pt);
      @(posedge clk); #1;
      cnt = 1;
      while (!out_valid && cnt < 40) begin
        @(posedge clk); #1;
        cnt++;
      end
      check("b2b_latency", 128'(cnt), 128'(11));
      check("b2b_data", out_data, exp);
      if (b < 3) begin
        pt = rand128();
        in_data = pt;
        #1;
        check("b2b_bypass", 128'({in_ready, rk_addr}), 128'({1'b1, 4'd0}));
      end else begin
        in_valid = 1'b0;
      end
    end
    @(posedge clk); #1;
    out_ready = 1'b0;
    check("b2b_drain", 128'({out_valid, busy}), 128'(0));

    // Reset asserted mid-operation at rnd=5
    in_data = rand128(); in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    cnt = 1;
    while (rk_addr != 4'd5 && cnt < 20) begin
      @(posedge clk); #1;
      cnt++;
    end
    check("midrst_reach_rnd5", 128'(cnt), 128'(5));
    rst = 1'b1;
    #1;
    check_reset_outputs("midrst");
    @(posedge clk); #1;
    rst = 1'b0;
    cnt = 0;
    for (int i = 0; i < 12; i++) begin
      @(posedge clk); #1;
      if (out_valid) cnt++;
    end
    check("midrst_no_output", 128'(cnt), 128'(0));
    run_one("midrst_next", 128'h00112233445566778899aabbccddeeff,
            128'h69c4e0d86a7b0430d8cdb78070b4c55a, 0);

`ifdef AES_ROUND_CTRL_ABORT_EN
    // Abort at rnd=3
    in_data = rand128(); in_valid = 1'b1; out_ready = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    cnt = 1;
    while (rk_addr != 4'd3 && cnt < 20) begin
      @(posedge clk); #1;
      cnt++;
    end
    check("abort_reach_rnd3", 128'(cnt), 128'(3));
    abort = 1'b1;
    @(posedge clk); #1;
    abort = 1'b0;
    check("abort_idle", 128'({busy, out_valid, in_ready, rk_addr}), 128'({1'b0, 1'b0, 1'b1, 4'd0}));
    cnt = 0;
    for (int i = 0; i < 12; i++) begin
      @(posedge clk); #1;
      if (out_valid) cnt++;
    end
    check("abort_no_output", 128'(cnt), 128'(0));
    out_ready = 1'b0;
    pt = rand128();
    run_one("abort_next", pt, ref10(pt), 0);
`endif

    // FIPS-197 C.3 on the NR=14 instance
    check("nr14_idle", 128'({ir14, bsy14, ov14}), 128'({1'b1, 1'b0, 1'b0}));
    id14 = 128'h00112233445566778899aabbccddeeff; iv14 = 1'b1; or14 = 1'b1;
    @(posedge clk); #1;
    iv14 = 1'b0;
    cnt = 1;
    while (!ov14 && cnt < 40) begin
      @(posedge clk); #1;
      cnt++;
    end
    check("nr14_latency", 128'(cnt), 128'(15));
    check("nr14_data", od14, 128'h8ea2b7ca516745bfeafc49904b496089);
    @(posedge clk); #1;
    or14 = 1'b0;
    check("nr14_released", 128'({ov14, bsy14}), 128'(0));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
